alu_sequencer: RTL and testbench

Multi-cycle front end for the 16-bit combinational ALU. It accepts operation requests over a valid/ready handshake and drives the ALU's operand and opcode inputs. It captures the ALU result and flags and returns them over a second valid/ready handshake. For 16x16 multiply (low 16 bits), it iterates the ALU's ADD over 16 cycles using shift-and-add. It sits between the control unit and the ALU instance, and is the only block that drives the ALU inputs.

---
 rtl/alu_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle front end for the 16-bit ALU: single ops in one cycle and
// 16x16 (low half) multiply via 16 shift-and-add iterations of the ALU ADD.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_code,
  input  logic [15:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero
);

  localparam int unsigned W    = 16;
  localparam int unsigned CW   = 3;
  localparam int unsigned OPW  = 4;
  localparam int unsigned CNTW = 4;

  localparam logic [OPW-1:0]  OP_MUL   = 4'b1000;
  localparam logic [CW-1:0]   CODE_ADD = 3'b000;
  localparam logic [CNTW-1:0] CNT_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic            c_q, c_d;
  logic            rsp_valid_d;
  logic [W-1:0]    rsp_data_d;
  logic            rsp_carry_d;
  logic            rsp_zero_d;
  logic [W-1:0]    alu_a_d;
  logic [W-1:0]    alu_b_d;
  logic [CW-1:0]   alu_code_d;

  // Acceptance is only possible in IDLE and never while reset is held.
  assign req_ready = rst_n && (state_q == IDLE);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      c_q       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_code  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      c_q       <= c_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_carry <= rsp_carry_d;
      rsp_zero  <= rsp_zero_d;
      alu_a     <= alu_a_d;
      alu_b     <= alu_b_d;
      alu_code  <= alu_code_d;
    end
  end

  // Next-state, datapath and response capture.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    c_d         = c_q;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_carry_d = rsp_carry;
    rsp_zero_d  = rsp_zero;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          if (req_op == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = req_a;
            mplier_d = req_b;
            c_d      = 1'b0;
            cnt_d    = '0;
            state_d  = MUL;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (!op_q[OPW-1]) begin
          rsp_data_d  = alu_out;
          rsp_zero_d  = alu_zero;
          // ALU carry is only meaningful for ADD.
          rsp_carry_d = (op_q[CW-1:0] == CODE_ADD) && alu_carry;
        end else begin
          rsp_data_d  = '0;
          rsp_zero_d  = 1'b1;
          rsp_carry_d = 1'b0;
        end
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      MUL: begin
        acc_d    = alu_out;
        c_d      = c_q | alu_carry;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNTW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          rsp_data_d  = alu_out;
          rsp_zero_d  = (alu_out == '0);
          rsp_carry_d = c_q | alu_carry;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU inputs are registered from the values the next state will hold.
  always_comb begin
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_code_d = '0;
    case (state_d)
      EXEC: begin
        alu_a_d    = a_d;
        alu_b_d    = b_d;
        alu_code_d = op_d[CW-1:0];
      end
      MUL: begin
        alu_a_d    = acc_d;
        alu_b_d    = mplier_d[0] ? mcand_d : W'(0);
        alu_code_d = CODE_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU stand-in.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_carry;
  logic        rsp_zero;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_code;
  logic [15:0] alu_out;
  logic        alu_carry;
  logic        alu_zero;

  int passed = 0;
  int total  = 0;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
    .alu_out(alu_out), .alu_carry(alu_carry), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // ALU stand-in; carry is deliberately 1 for non-ADD codes so masking is visible.
  always_comb begin
    logic [16:0] s;
    s = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = 1'b1;
    case (alu_code)
      3'b000: begin alu_out = s[15:0]; alu_carry = s[16]; end
      3'b001: alu_out = alu_a - alu_b;
      3'b010: alu_out = alu_a | alu_b;
      3'b011: alu_out = alu_a ^ alu_b;
      3'b100: alu_out = alu_a & alu_b;
      default: alu_out = alu_a;
    endcase
    alu_zero = (alu_out == 16'h0000);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issue one request at the current negedge and wait for rsp_valid (no handshake).
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        output logic rdy, output int lat, output logic [15:0] d,
                        output logic cy, output logic z);
    rdy = req_ready;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0; req_op = 4'hF; req_a = 16'hDEAD; req_b = 16'hBEEF;
      lat++;
    end while (!rsp_valid && lat < 40);
    d = rsp_data; cy = rsp_carry; z = rsp_zero;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 4'h0; req_a = 16'h0; req_b = 16'h0;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, alu_a, alu_b, alu_code} !== '0)
      $display("FAIL reset_outputs: rdy=%b vld=%b data=%h c=%b z=%b alu=%h/%h/%h, required all 0",
               req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, alu_a, alu_b, alu_code);
    else passed++;
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) $display("FAIL reset_ready_release: got %b, required 1", req_ready);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_single(input string name, input logic [3:0] op, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] ed, input logic ec,
                             input logic ez);
    logic rdy, cy, z; int lat; logic [15:0] d;
    run_op(op, a, b, rdy, lat, d, cy, z);
    total++;
    if ({rdy, d, cy, z} !== {1'b1, ed, ec, ez} || lat != 2)
      $display("FAIL %s: rdy=%b lat=%0d data=%h c=%b z=%b, required rdy=1 lat=2 data=%h c=%b z=%b",
               name, rdy, lat, d, cy, z, ed, ec, ez);
    else passed++;
    handshake();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL %s_after_hs: vld=%b rdy=%b, required vld=0 rdy=1", name, rsp_valid, req_ready);
    else passed++;
  endtask

  task automatic test_mul(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] ed, input logic ec, input logic ez);
    logic rdy, cy, z; int lat; logic [15:0] d;
    run_op(4'b1000, a, b, rdy, lat, d, cy, z);
    total++;
    if ({rdy, d, cy, z} !== {1'b1, ed, ec, ez} || lat != 17)
      $display("FAIL %s: rdy=%b lat=%0d data=%h c=%b z=%b, required rdy=1 lat=17 data=%h c=%b z=%b",
               name, rdy, lat, d, cy, z, ed, ec, ez);
    else passed++;
    handshake();
  endtask

  task automatic test_back_to_back();
    logic rdy, cy, z; int lat; logic [15:0] d;
    run_op(4'b0000, 16'h1000, 16'h0234, rdy, lat, d, cy, z);
    total++;
    if (d !== 16'h1234 || lat != 2)
      $display("FAIL bp_first: data=%h lat=%0d, required 1234 lat=2", d, lat);
    else passed++;
    // Second request (XOR) held pending while the response is back-pressured.
    req_valid = 1'b1; req_op = 4'b0011; req_a = 16'h00FF; req_b = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({rsp_valid, req_ready, rsp_data, rsp_carry, rsp_zero} !== {1'b1, 1'b0, 16'h1234, 1'b0, 1'b0})
        $display("FAIL bp_hold_%0d: vld=%b rdy=%b data=%h c=%b z=%b, required vld=1 rdy=0 data=1234 c=0 z=0",
                 i, rsp_valid, req_ready, rsp_data, rsp_carry, rsp_zero);
      else passed++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL bp_idle: vld=%b rdy=%b, required vld=0 rdy=1", rsp_valid, req_ready);
    else passed++;
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL bp_second_exec: rdy=%b vld=%b, required rdy=0 vld=0", req_ready, rsp_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0FF0 || rsp_carry !== 1'b0 || rsp_zero !== 1'b0)
      $display("FAIL bp_second_rsp: vld=%b data=%h c=%b z=%b, required vld=1 data=0ff0 c=0 z=0",
               rsp_valid, rsp_data, rsp_carry, rsp_zero);
    else passed++;
    handshake();
  endtask

  task automatic test_reset_mid_mul();
    logic seen;
    req_valid = 1'b1; req_op = 4'b1000; req_a = 16'd300; req_b = 16'd200;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, alu_a, alu_b, alu_code} !== '0)
      $display("FAIL midreset_outputs: rdy=%b vld=%b data=%h c=%b z=%b alu=%h/%h/%h, required all 0",
               req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero, alu_a, alu_b, alu_code);
    else passed++;
    rst_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1) $display("FAIL midreset_ready: got %b, required 1", req_ready);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL midreset_no_rsp: rsp_valid seen=%b, required 0", seen);
    else passed++;
    test_single("post_reset_add", 4'b0000, 16'd2, 16'd3, 16'd5, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single("add_wrap", 4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    test_single("sub", 4'b0001, 16'd5, 16'd7, 16'hFFFE, 1'b0, 1'b0);
    test_single("and", 4'b0100, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b0, 1'b1);
    test_single("reserved", 4'b1010, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1);
    test_mul("mul_300x200", 16'd300, 16'd200, 16'hEA60, 1'b0, 1'b0);
    test_mul("mul_0100sq", 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b1);
    test_mul("mul_ffffsq", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
